// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe controller slice.
package ttt_pkg;

    localparam int unsigned BOARD_W = 9;

    typedef logic [BOARD_W-1:0] board_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AI_THINK,
        S_CHECK_X,
        S_HUMAN_WAIT,
        S_CHECK_O,
        S_DONE
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Bit 8 is the top-left cell, bit 0 the bottom-right.
    localparam int unsigned NUM_LINES = 8;
    localparam logic [NUM_LINES-1:0][BOARD_W-1:0] LINE_MASKS = {
        9'b111000000, 9'b000111000, 9'b000000111,
        9'b100100100, 9'b010010010, 9'b001001001,
        9'b100010001, 9'b001010100
    };

endpackage

// File: rtl/ttt_game_ctrl_if.sv
// Human move valid/ready handshake between the input logic and the controller.
interface ttt_game_ctrl_if
    import ttt_pkg::*;
();
    board_t human_move;
    logic   human_move_valid;
    logic   human_move_ready;

    modport master (output human_move, output human_move_valid, input  human_move_ready);
    modport slave  (input  human_move, input  human_move_valid, output human_move_ready);
endinterface

// File: rtl/ttt_win_detect.sv
// Flags a board that fully covers any of the eight winning lines.
module ttt_win_detect
    import ttt_pkg::*;
(
    input  board_t board,
    output logic   has_line
);

    always_comb begin
        has_line = 1'b0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            if ((board & LINE_MASKS[i]) == LINE_MASKS[i]) has_line = 1'b1;
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn sequencer: owns the X/O boards, commits AI and human moves,
// and reports win/draw/forfeit results.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int unsigned AI_SETTLE     = 1,
    parameter int unsigned HUMAN_TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    ttt_game_ctrl_if.slave  human,
    input  board_t          ai_move,
    output board_t          x_state,
    output board_t          o_state,
    output logic            ai_turn,
    output logic            illegal_move,
    output logic            game_over,
    output logic [1:0]      winner
);

    localparam int unsigned SW = (AI_SETTLE > 1) ? $clog2(AI_SETTLE) : 1;
    localparam int unsigned TW = (HUMAN_TIMEOUT > 0) ? $clog2(HUMAN_TIMEOUT + 1) : 1;

    state_t        state, state_d;
    board_t        x_d, o_d;
    logic [1:0]    winner_d;
    logic [3:0]    move_cnt, move_cnt_d;
    logic [SW-1:0] settle_cnt, settle_cnt_d;
    logic [TW-1:0] to_cnt, to_cnt_d;
    logic          illegal_d;

    board_t empty, fallback, chosen;
    logic   ai_ok, xfer, human_ok, x_line, o_line;

    ttt_win_detect u_win_x (.board(x_state), .has_line(x_line));
    ttt_win_detect u_win_o (.board(o_state), .has_line(o_line));

    assign empty    = ~(x_state | o_state);
    // Two's-complement trick isolates the lowest-index empty cell.
    assign fallback = empty & (~empty + BOARD_W'(1));
    assign ai_ok    = $onehot(ai_move) && ((ai_move & ~empty) == '0);
    assign chosen   = ai_ok ? ai_move : fallback;

    assign xfer     = human.human_move_valid && human.human_move_ready;
    assign human_ok = $onehot(human.human_move) && ((human.human_move & ~empty) == '0);

    assign human.human_move_ready = (state == S_HUMAN_WAIT);
    assign ai_turn                = (state == S_AI_THINK);
    assign game_over              = (state == S_DONE);

    always_comb begin
        state_d      = state;
        x_d          = x_state;
        o_d          = o_state;
        winner_d     = winner;
        move_cnt_d   = move_cnt;
        settle_cnt_d = '0;
        to_cnt_d     = '0;
        illegal_d    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    x_d        = '0;
                    o_d        = '0;
                    winner_d   = WIN_NONE;
                    move_cnt_d = '0;
                    state_d    = S_AI_THINK;
                end
            end
            S_AI_THINK: begin
                if (settle_cnt == SW'(AI_SETTLE - 1)) begin
                    x_d        = x_state | chosen;
                    move_cnt_d = move_cnt + 4'd1;
                    state_d    = S_CHECK_X;
                end else begin
                    settle_cnt_d = settle_cnt + SW'(1);
                end
            end
            S_CHECK_X: begin
                if (x_line) begin
                    winner_d = WIN_X;
                    state_d  = S_DONE;
                end else if (move_cnt == 4'd9) begin
                    winner_d = WIN_DRAW;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_HUMAN_WAIT;
                end
            end
            S_HUMAN_WAIT: begin
                if (xfer && human_ok) begin
                    o_d        = o_state | human.human_move;
                    move_cnt_d = move_cnt + 4'd1;
                    state_d    = S_CHECK_O;
                end else begin
                    illegal_d = xfer;
                    to_cnt_d  = to_cnt + TW'(1);
                    // Counter value N-1 here means N cycles have elapsed after this edge.
                    if (HUMAN_TIMEOUT != 0 && to_cnt == TW'(HUMAN_TIMEOUT - 1)) begin
                        winner_d = WIN_X;
                        state_d  = S_DONE;
                    end
                end
            end
            S_CHECK_O: begin
                if (o_line) begin
                    winner_d = WIN_O;
                    state_d  = S_DONE;
                end else if (move_cnt == 4'd9) begin
                    winner_d = WIN_DRAW;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_AI_THINK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            x_state      <= '0;
            o_state      <= '0;
            winner       <= WIN_NONE;
            move_cnt     <= '0;
            settle_cnt   <= '0;
            to_cnt       <= '0;
            illegal_move <= 1'b0;
        end else begin
            state        <= state_d;
            x_state      <= x_d;
            o_state      <= o_d;
            winner       <= winner_d;
            move_cnt     <= move_cnt_d;
            settle_cnt   <= settle_cnt_d;
            to_cnt       <= to_cnt_d;
            illegal_move <= illegal_d;
        end
    end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Scoreboard bench for ttt_game_ctrl: a reference AI drives ai_move, expected
// observations are queued as stimulus is applied and popped when sampled.
module tb_ttt_game_ctrl;

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] o;
        logic [1:0] win;
        logic       over;
        logic       rdy;
        logic       turn;
        logic       ill;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, start2 = 1'b0;
    logic [8:0] ai_move, ai_move2, ai_forced = '0;
    logic       ai_force = 1'b0;
    logic [8:0] x_state, o_state, x2, o2;
    logic       ai_turn, illegal_move, game_over, turn2, ill2, over2;
    logic [1:0] winner, win2;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    obs_t        exp_q[$];
    string       tag_q[$];
    obs_t        got, e;
    string       t;
    bit          ok;

    ttt_game_ctrl_if hif();
    ttt_game_ctrl_if hif2();

    ttt_game_ctrl #(.AI_SETTLE(1), .HUMAN_TIMEOUT(0)) dut (
        .clk(clk), .rst(rst), .start(start), .human(hif), .ai_move(ai_move),
        .x_state(x_state), .o_state(o_state), .ai_turn(ai_turn),
        .illegal_move(illegal_move), .game_over(game_over), .winner(winner)
    );

    ttt_game_ctrl #(.AI_SETTLE(2), .HUMAN_TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .start(start2), .human(hif2), .ai_move(ai_move2),
        .x_state(x2), .o_state(o2), .ai_turn(turn2),
        .illegal_move(ill2), .game_over(over2), .winner(win2)
    );

    always #5 clk = ~clk;

    // Reference AI: complete an open X line, else take cells in a fixed preference order.
    function automatic logic [8:0] model_ai(input logic [8:0] x, input logic [8:0] o);
        logic [8:0] lines [8];
        int         order [9];
        lines = '{9'b111000000, 9'b000111000, 9'b000000111, 9'b100100100,
                  9'b010010010, 9'b001001001, 9'b100010001, 9'b001010100};
        order = '{8, 6, 2, 0, 4, 7, 5, 3, 1};
        for (int i = 0; i < 8; i++)
            if ($countones(x & lines[i]) == 2 && (o & lines[i]) == '0) return lines[i] & ~x;
        for (int i = 0; i < 9; i++)
            if (!x[order[i]] && !o[order[i]]) return 9'b1 << order[i];
        return '0;
    endfunction

    assign ai_move  = ai_force ? ai_forced : model_ai(x_state, o_state);
    assign ai_move2 = model_ai(x2, o2);

    function automatic obs_t mk(input logic [8:0] x, input logic [8:0] o, input logic [1:0] w,
                                input logic over, input logic rdy, input logic turn, input logic ill);
        mk = '{x: x, o: o, win: w, over: over, rdy: rdy, turn: turn, ill: ill};
    endfunction

    function automatic obs_t snap1();
        snap1 = mk(x_state, o_state, winner, game_over, hif.human_move_ready, ai_turn, illegal_move);
    endfunction

    function automatic obs_t snap2();
        snap2 = mk(x2, o2, win2, over2, hif2.human_move_ready, turn2, ill2);
    endfunction

    function automatic string fmt(input obs_t s);
        fmt = $sformatf("x=%b o=%b win=%b over=%b rdy=%b turn=%b ill=%b",
                        s.x, s.o, s.win, s.over, s.rdy, s.turn, s.ill);
    endfunction

    task automatic push(input string tag, input obs_t ex);
        exp_q.push_back(ex);
        tag_q.push_back(tag);
    endtask

    task automatic wait_ready(input bit second, input int budget, output bit done);
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (second ? hif2.human_move_ready : hif.human_move_ready) begin
                done = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_over(input int budget, output bit done);
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (game_over) begin
                done = 1'b1;
                return;
            end
        end
    endtask

    task automatic play_o(input logic [8:0] mv);
        hif.human_move       = mv;
        hif.human_move_valid = 1'b1;
        @(negedge clk);
        hif.human_move_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        push("reset", mk('0, '0, 2'b00, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        got = snap1(); e = exp_q.pop_front(); t = tag_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL %s: got %s required %s", t, fmt(got), fmt(e)); end
        rst = 1'b0;
    endtask

    task automatic test_start();
        start = 1'b1;
        push("start_ai_think", mk('0, '0, 2'b00, 0, 0, 1, 0));
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) push("first_x_move", mk(9'b100000000, '0, 2'b00, 0, 0, 0, 0));
            if (i == 2) push("first_ready",  mk(9'b100000000, '0, 2'b00, 0, 1, 0, 0));
            if (i > 0) @(negedge clk);
            got = snap1(); e = exp_q.pop_front(); t = tag_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL %s: got %s required %s", t, fmt(got), fmt(e)); end
        end
    endtask

    task automatic test_illegal();
        logic [8:0] bad [2];
        bad = '{9'b100000000, 9'b000000011};
        for (int i = 0; i < 2; i++) begin
            push($sformatf("illegal_pulse_%0d", i), mk(9'b100000000, '0, 2'b00, 0, 1, 0, 1));
            play_o(bad[i]);
            got = snap1(); e = exp_q.pop_front(); t = tag_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL %s: got %s required %s", t, fmt(got), fmt(e)); end
            push($sformatf("illegal_end_%0d", i), mk(9'b100000000, '0, 2'b00, 0, 1, 0, 0));
            @(negedge clk);
            got = snap1(); e = exp_q.pop_front(); t = tag_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL %s: got %s required %s", t, fmt(got), fmt(e)); end
        end
    endtask

    task automatic test_x_win();
        push("o_commit", mk(9'b100000000, 9'b000000001, 2'b00, 0, 0, 0, 0));
        play_o(9'b000000001);
        got = snap1(); e = exp_q.pop_front(); t = tag_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL %s: got %s required %s", t, fmt(got), fmt(e)); end
        push("ai_second", mk(9'b101000000, 9'b000000001, 2'b00, 0, 1, 0, 0));
        wait_ready(0, 10, ok);
        if (!ok) begin vectors++; miscompares++; $display("FAIL ready_wait: timed out, required ready=1"); end
        got = snap1(); e = exp_q.pop_front(); t = tag_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL %s: got %s required %s", t, fmt(got), fmt(e)); end
        push("x_wins", mk(9'b111000000, 9'b000000011, 2'b01, 1, 0, 0, 0));
        push("done_hold", mk(9'b111000000, 9'b000000011, 2'b01, 1, 0, 0, 0));
        play_o(9'b000000010);
        wait_over(10, ok);
        if (!ok) begin vectors++; miscompares++; $display("FAIL over_wait: timed out, required game_over=1"); end
        for (int i = 0; i < 2; i++) begin
            if (i == 1) repeat (3) @(negedge clk);
            got = snap1(); e = exp_q.pop_front(); t = tag_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL %s: got %s required %s", t, fmt(got), fmt(e)); end
        end
        start = 1'b1;
        push("restart_clear", mk('0, '0, 2'b00, 0, 0, 1, 0));
        @(negedge clk);
        start = 1'b0;
        got = snap1(); e = exp_q.pop_front(); t = tag_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL %s: got %s required %s", t, fmt(got), fmt(e)); end
        push("restart_first_x", mk(9'b100000000, '0, 2'b00, 0, 0, 0, 0));
        @(negedge clk);
        got = snap1(); e = exp_q.pop_front(); t = tag_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL %s: got %s required %s", t, fmt(got), fmt(e)); end
        wait_ready(0, 10, ok);
        if (!ok) begin vectors++; miscompares++; $display("FAIL ready_wait: timed out, required ready=1"); end
    endtask

    task automatic test_fallback();
        logic [8:0] forced [3];
        logic [8:0] omv [3];
        logic [8:0] xexp [3];
        logic [8:0] oexp;
        forced = '{9'b000000000, 9'b100000000, 9'b000000011};
        omv    = '{9'b000000001, 9'b000001000, 9'b000100000};
        xexp   = '{9'b100000010, 9'b100000110, 9'b100010110};
        oexp   = '0;
        ai_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ai_forced = forced[i];
            oexp = oexp | omv[i];
            push($sformatf("fallback_%0d", i), mk(xexp[i], oexp, 2'b00, 0, 1, 0, 0));
            play_o(omv[i]);
            wait_ready(0, 10, ok);
            if (!ok) begin vectors++; miscompares++; $display("FAIL ready_wait: timed out, required ready=1"); end
            got = snap1(); e = exp_q.pop_front(); t = tag_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL %s: got %s required %s", t, fmt(got), fmt(e)); end
        end
        ai_force = 1'b0;
    endtask

    task automatic test_reset_midgame();
        rst = 1'b1;
        push("reset_midgame", mk('0, '0, 2'b00, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        got = snap1(); e = exp_q.pop_front(); t = tag_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL %s: got %s required %s", t, fmt(got), fmt(e)); end
    endtask

    task automatic test_draw();
        logic [8:0] xs [5];
        logic [8:0] os [4];
        logic [8:0] xe, oe;
        xs = '{9'b100000000, 9'b001000000, 9'b000100000, 9'b000000010, 9'b000000001};
        os = '{9'b010000000, 9'b000010000, 9'b000001000, 9'b000000100};
        xe = '0; oe = '0;
        ai_force = 1'b1;
        ai_forced = xs[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            xe = xe | xs[i];
            if (i < 4) begin
                push($sformatf("draw_x_%0d", i), mk(xe, oe, 2'b00, 0, 1, 0, 0));
                wait_ready(0, 10, ok);
                if (!ok) begin vectors++; miscompares++; $display("FAIL ready_wait: timed out, required ready=1"); end
            end else begin
                push("draw_result", mk(xe, oe, 2'b11, 1, 0, 0, 0));
                wait_over(10, ok);
                if (!ok) begin vectors++; miscompares++; $display("FAIL over_wait: timed out, required game_over=1"); end
            end
            got = snap1(); e = exp_q.pop_front(); t = tag_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL %s: got %s required %s", t, fmt(got), fmt(e)); end
            if (i < 4) begin
                ai_forced = xs[i+1];
                oe = oe | os[i];
                play_o(os[i]);
            end
        end
        vectors++;
        if ($countones(x_state | o_state) != 9) begin
            miscompares++;
            $display("FAIL draw_cells: got %0d filled cells required 9", $countones(x_state | o_state));
        end
        ai_force = 1'b0;
    endtask

    task automatic test_timeout();
        int unsigned turn_n, rdy_n;
        turn_n = 0; rdy_n = 0; ok = 1'b0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        push("timeout_forfeit", mk(9'b100000000, '0, 2'b01, 1, 0, 0, 0));
        for (int i = 0; i < 30; i++) begin
            if (over2) begin ok = 1'b1; break; end
            turn_n += 32'(turn2);
            rdy_n  += 32'(hif2.human_move_ready);
            @(negedge clk);
        end
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL timeout_wait: got game_over=0 required 1"); end
        vectors++;
        if (turn_n != 2) begin miscompares++; $display("FAIL settle_cycles: got %0d required 2", turn_n); end
        vectors++;
        if (rdy_n != 4) begin miscompares++; $display("FAIL wait_cycles: got %0d required 4", rdy_n); end
        got = snap2(); e = exp_q.pop_front(); t = tag_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL %s: got %s required %s", t, fmt(got), fmt(e)); end

        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_ready(1, 10, ok);
        if (!ok) begin vectors++; miscompares++; $display("FAIL ready_wait2: timed out, required ready=1"); end
        repeat (3) @(negedge clk);
        push("move_beats_timeout", mk(9'b100000000, 9'b000000001, 2'b00, 0, 0, 0, 0));
        hif2.human_move       = 9'b000000001;
        hif2.human_move_valid = 1'b1;
        @(negedge clk);
        hif2.human_move_valid = 1'b0;
        got = snap2(); e = exp_q.pop_front(); t = tag_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL %s: got %s required %s", t, fmt(got), fmt(e)); end
    endtask

    initial begin
        hif.human_move        = '0;
        hif.human_move_valid  = 1'b0;
        hif2.human_move       = '0;
        hif2.human_move_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_start();
        test_illegal();
        test_x_win();
        test_fallback();
        test_reset_midgame();
        test_draw();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
